// File: rtl/vram_rect_fill_if.sv
// Bundles the CPU register bus and the VRAM write port of the rectangle fill engine.
// The engine uses the slave view; the CPU/VRAM side (or a bench) uses the master view.
interface vram_rect_fill_if;
  logic [1:0]  bus_addr;
  logic        bus_wr_ena;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic [31:0] vram_wr_addr;
  logic [15:0] vram_wr_data;
  logic        vram_wr_ena;
  logic        vram_wr_ready;
  logic        irq;

  modport slave (
    input  bus_addr, bus_wr_ena, bus_wr_data, vram_wr_ready,
    output bus_rd_data, vram_wr_addr, vram_wr_data, vram_wr_ena, irq
  );

  modport master (
    output bus_addr, bus_wr_ena, bus_wr_data, vram_wr_ready,
    input  bus_rd_data, vram_wr_addr, vram_wr_data, vram_wr_ena, irq
  );
endinterface

// File: rtl/vram_rect_fill.sv
// CPU-programmable rectangle fill engine: writes one RGB565 colour into a W x H
// window of the linear VRAM layout, one pixel per accepted handshake.
module vram_rect_fill #(
  parameter int          DISPLAY_WIDTH      = 240,
  parameter int          DISPLAY_HEIGHT     = 320,
  parameter logic [3:0]  MMU_BANK_VRAM      = 4'h1,
  parameter logic [31:0] VRAM_START_ADDRESS = {MMU_BANK_VRAM, 28'h0}
) (
  input logic             clk,
  input logic             rst,
  vram_rect_fill_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] FILL    = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [31:0] WIDTH_32  = 32'(DISPLAY_WIDTH);
  localparam logic [16:0] WIDTH_17  = 17'(DISPLAY_WIDTH);
  localparam logic [16:0] HEIGHT_17 = 17'(DISPLAY_HEIGHT);

  logic [1:0]  state_q, state_d;
  logic [15:0] x0_q, x0_d, y0_q, y0_d;
  logic [15:0] w_q, w_d, h_q, h_d;
  logic [15:0] color_q, color_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] row_base_q, row_base_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        wr_ena_q, wr_ena_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ctrl_wr, start, abort, done_set, err_set, handshake;
  logic [16:0] x_end, y_end;

  assign ctrl_wr   = bus.bus_wr_ena && (bus.bus_addr == 2'd0);
  assign start     = ctrl_wr && bus.bus_wr_data[0] && !bus.bus_wr_data[1];
  assign abort     = ctrl_wr && bus.bus_wr_data[1];
  assign handshake = wr_ena_q && bus.vram_wr_ready;
  // Exclusive window ends at 17 bits so oversized requests cannot wrap into range.
  assign x_end     = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end     = {1'b0, y0_q} + {1'b0, h_q};

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_ena_d   = wr_ena_q;
    done_set   = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.bus_wr_ena) begin
          case (bus.bus_addr)
            2'd1:    {y0_d, x0_d} = bus.bus_wr_data;
            2'd2:    {h_d, w_d}   = bus.bus_wr_data;
            2'd3:    color_d      = bus.bus_wr_data[15:0];
            default: ;
          endcase
        end
        if (start) state_d = CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (w_q == 16'd0 || h_q == 16'd0) begin
          state_d = DONE_ST;
        end else if (x_end > WIDTH_17 || y_end > HEIGHT_17) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          row_base_d = VRAM_START_ADDRESS + 32'(y0_q) * WIDTH_32;
          x_d        = x0_q;
          y_d        = y0_q;
          wr_addr_d  = row_base_d + 32'(x0_q);
          wr_ena_d   = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (abort) begin
          wr_ena_d = 1'b0;
          state_d  = IDLE;
        end else if (handshake) begin
          if (({1'b0, x_q} + 17'd1) < x_end) begin
            x_d       = x_q + 16'd1;
            wr_addr_d = wr_addr_q + 32'd1;
          end else if (({1'b0, y_q} + 17'd1) < y_end) begin
            x_d        = x0_q;
            y_d        = y_q + 16'd1;
            row_base_d = row_base_q + WIDTH_32;
            wr_addr_d  = row_base_q + WIDTH_32 + 32'(x0_q);
          end else begin
            wr_ena_d = 1'b0;
            state_d  = DONE_ST;
          end
        end
      end
      default: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
    endcase

    // Sticky flags: a set in the same cycle as the write-1-to-clear wins.
    done_d = done_set || (done_q && !(ctrl_wr && bus.bus_wr_data[2]));
    err_d  = err_set  || (err_q  && !(ctrl_wr && bus.bus_wr_data[3]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= VRAM_START_ADDRESS;
      wr_addr_q  <= VRAM_START_ADDRESS;
      wr_ena_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wr_ena_q   <= wr_ena_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    case (bus.bus_addr)
      2'd0:    bus.bus_rd_data = {29'd0, err_q, done_q, (state_q != IDLE)};
      2'd1:    bus.bus_rd_data = {y0_q, x0_q};
      2'd2:    bus.bus_rd_data = {h_q, w_q};
      default: bus.bus_rd_data = {16'd0, color_q};
    endcase
  end

  assign bus.vram_wr_addr = wr_addr_q;
  assign bus.vram_wr_data = color_q;
  assign bus.vram_wr_ena  = wr_ena_q;
  assign bus.irq          = done_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Randomized self-checking bench for vram_rect_fill: a pixel-list model of each fill
// is compared against every VRAM handshake, plus register/status checks.
module tb_vram_rect_fill;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk;
  logic rst;
  vram_rect_fill_if vif ();

  vram_rect_fill dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int vectors    = 0;
  int miscompares = 0;
  int hs_count   = 0;
  bit rdy_rand   = 1'b0;

  logic [31:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [31:0] hs_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ready driver: held high or randomly toggled, changed just after each rising edge.
  initial begin
    vif.vram_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vif.vram_wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every handshake must match the next pixel of the model,
  // and a stalled request must stay unchanged.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (vif.vram_wr_ena && prev_stall) begin
          check("stall_addr_hold", vif.vram_wr_addr, prev_addr);
          check("stall_data_hold", {16'd0, vif.vram_wr_data}, {16'd0, prev_data});
        end
        if (vif.vram_wr_ena && vif.vram_wr_ready) begin
          hs_count++;
          hs_log.push_back(vif.vram_wr_addr);
          if (exp_addr.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL extra_write: got addr %h, expected no write", vif.vram_wr_addr);
          end else begin
            check("wr_addr", vif.vram_wr_addr, exp_addr.pop_front());
            check("wr_data", {16'd0, vif.vram_wr_data}, {16'd0, exp_data.pop_front()});
          end
        end
        prev_stall = vif.vram_wr_ena && !vif.vram_wr_ready;
        prev_addr  = vif.vram_wr_addr;
        prev_data  = vif.vram_wr_data;
      end
    end
  end

  // All bus tasks start and end just after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    vif.bus_addr    = a;
    vif.bus_wr_data = d;
    vif.bus_wr_ena  = 1'b1;
    @(posedge clk);
    #1;
    vif.bus_wr_ena  = 1'b0;
    vif.bus_wr_data = '0;
  endtask

  task automatic bus_read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    vif.bus_addr = a;
    #1;
    check(name, vif.bus_rd_data, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      vif.bus_addr = 2'd0;
      #1;
      if (!vif.bus_rd_data[0]) break;
      if (n >= budget) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL busy_timeout: got BUSY=1 after %0d cycles, expected idle", n);
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Reference: the expected pixel list follows directly from the rectangle rules.
  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input logic [15:0] color, input string tag);
    bit exp_done, exp_err;
    int start_cnt, exp_cnt;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_cnt  = 0;
    if (w == 0 || h == 0) begin
      exp_done = 1'b1;
    end else if (x0 + w > 240 || y0 + h > 320) begin
      exp_err = 1'b1;
    end else begin
      exp_done = 1'b1;
      for (int yy = y0; yy < y0 + h; yy++)
        for (int xx = x0; xx < x0 + w; xx++) begin
          exp_addr.push_back(BASE + 32'(yy * 240 + xx));
          exp_data.push_back(color);
          exp_cnt++;
        end
    end
    bus_write(2'd1, {16'(y0), 16'(x0)});
    bus_write(2'd2, {16'(h), 16'(w)});
    bus_write(2'd3, {16'hFFFF, color});
    bus_read_check(2'd3, {16'd0, color}, {tag, "_color_rd"});
    start_cnt = hs_count;
    bus_write(2'd0, 32'h1);
    wait_idle(w * h * 20 + 50);
    check({tag, "_hs_count"}, 32'(hs_count - start_cnt), 32'(exp_cnt));
    check({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    bus_read_check(2'd0, {29'd0, exp_err, exp_done, 1'b0}, {tag, "_status"});
    check({tag, "_irq"}, {31'd0, vif.irq}, {31'd0, exp_done});
    exp_addr.delete();
    exp_data.delete();
    bus_write(2'd0, 32'hC);
    bus_read_check(2'd0, 32'd0, {tag, "_status_clr"});
    check({tag, "_irq_clr"}, {31'd0, vif.irq}, 32'd0);
  endtask

  initial begin
    int n, start_cnt;
    rst               = 1'b1;
    vif.bus_addr      = '0;
    vif.bus_wr_ena    = 1'b0;
    vif.bus_wr_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ena", {31'd0, vif.vram_wr_ena}, 32'd0);
    check("rst_addr", vif.vram_wr_addr, BASE);
    check("rst_data", {16'd0, vif.vram_wr_data}, 32'd0);
    check("rst_irq", {31'd0, vif.irq}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) bus_read_check(2'(a), 32'd0, "rst_reg");

    // Row of four red pixels; pin the first and last address literally.
    hs_log.delete();
    run_fill(0, 0, 4, 1, 16'hF800, "t1");
    check("t1_lit_first", hs_log[0], 32'h1000_0000);
    check("t1_lit_last", hs_log[3], 32'h1000_0003);

    // 2x2 at the right edge: row wrap goes to the next row, never to 720.
    hs_log.delete();
    run_fill(238, 2, 2, 2, 16'h07E0, "t2");
    check("t2_lit0", hs_log[0], 32'h1000_02CE);
    check("t2_lit1", hs_log[1], 32'h1000_02CF);
    check("t2_lit2", hs_log[2], 32'h1000_03BE);
    check("t2_lit3", hs_log[3], 32'h1000_03BF);

    run_fill(239, 0, 2, 1, 16'h1234, "t3_err");
    run_fill(0, 0, 0, 5, 16'h1234, "t3_zero");
    run_fill(0, 319, 1, 2, 16'h5555, "t3_yerr");

    // START and ABORT together: nothing starts.
    start_cnt = hs_count;
    bus_write(2'd2, {16'd3, 16'd3});
    bus_write(2'd0, 32'h3);
    bus_read_check(2'd0, 32'd0, "start_abort_status");
    repeat (5) @(posedge clk);
    #1;
    check("start_abort_hs", 32'(hs_count - start_cnt), 32'd0);

    rdy_rand = 1'b1;
    run_fill(5, 7, 2, 2, 16'hABCD, "t4");

    // Abort after the seventh handshake of a 10x10 fill.
    rdy_rand = 1'b0;
    for (int yy = 100; yy < 110; yy++)
      for (int xx = 100; xx < 110; xx++) begin
        exp_addr.push_back(BASE + 32'(yy * 240 + xx));
        exp_data.push_back(16'h00FF);
      end
    bus_write(2'd1, {16'd100, 16'd100});
    bus_write(2'd2, {16'd10, 16'd10});
    bus_write(2'd3, 32'h00FF);
    start_cnt = hs_count;
    bus_write(2'd0, 32'h1);
    n = 0;
    while (hs_count - start_cnt < 7 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL abort_wait: got %0d handshakes, expected 7", hs_count - start_cnt);
    end
    bus_write(2'd0, 32'h2);
    check("abort_ena_low", {31'd0, vif.vram_wr_ena}, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    check("abort_hs_le8", {31'd0, (hs_count - start_cnt) <= 8}, 32'd1);
    bus_read_check(2'd0, 32'd0, "abort_status");
    repeat (4) @(posedge clk);
    #1;
    run_fill(0, 0, 4, 3, 16'h0F0F, "after_abort");

    // Randomized windows, some hugging or crossing the screen edges.
    rdy_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int x0, y0;
      x0 = $urandom_range(0, 1) ? int'($urandom_range(232, 239)) : int'($urandom_range(0, 200));
      y0 = $urandom_range(0, 1) ? int'($urandom_range(312, 319)) : int'($urandom_range(0, 300));
      run_fill(x0, y0, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               16'($urandom), "rnd");
    end

    // Asynchronous reset in the middle of a fill.
    rdy_rand = 1'b0;
    for (int yy = 0; yy < 10; yy++)
      for (int xx = 0; xx < 10; xx++) begin
        exp_addr.push_back(BASE + 32'(yy * 240 + xx));
        exp_data.push_back(16'hCAFE);
      end
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, {16'd10, 16'd10});
    bus_write(2'd3, 32'hCAFE);
    bus_write(2'd0, 32'h1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ena", {31'd0, vif.vram_wr_ena}, 32'd0);
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 4; a++) bus_read_check(2'(a), 32'd0, "post_rst_reg");
    start_cnt = hs_count;
    bus_write(2'd0, 32'h1);
    wait_idle(20);
    check("post_rst_hs", 32'(hs_count - start_cnt), 32'd0);
    bus_read_check(2'd0, 32'd2, "post_rst_status");
    check("post_rst_irq", {31'd0, vif.irq}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- CPU-programmable rectangle fill engine upstream of the ILI9341 display peripheral.
- Writes a solid RGB565 colour into a W×H window of VRAM, one pixel per accepted cycle.
- Uses the same linear layout the display scanner reads: addr = VRAM_START_ADDRESS + y*DISPLAY_WIDTH + x.
- Sits on the CPU peripheral bus (4 word registers); owns the VRAM write port.

Parameters:
- DISPLAY_WIDTH, 240: pixels per row; also the row stride.
- DISPLAY_HEIGHT, 320: number of rows.
- VRAM_START_ADDRESS, {MMU_BANK_VRAM, 28'h0}: base address added to every VRAM write address.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- bus_addr  input  2  register word select.
- bus_wr_ena  input  1  register write strobe.
- bus_wr_data  input  32  register write data.
- bus_rd_data  output  32  register read data; combinational from bus_addr.
- vram_wr_addr  output  32  VRAM write address.
- vram_wr_data  output  16  pixel colour, RGB565.
- vram_wr_ena  output  1  write valid.
- vram_wr_ready  input  1  VRAM accepts the write this cycle.
- irq  output  1  equals the DONE sticky bit.

Behaviour:
- Reset is asynchronous and active-high on rst, clocked by clk. Reset values:
  - All registers 0; state IDLE.
  - vram_wr_ena=0, vram_wr_addr=VRAM_START_ADDRESS, vram_wr_data=0, irq=0.
- Register map (bus_addr):
  - 0 CTRL/STATUS.
    - Write bit0 START, bit1 ABORT, bit2 DONE_CLR (write-1-to-clear DONE), bit3 ERR_CLR.
    - Read bit0 BUSY, bit1 DONE, bit2 ERR; other bits read 0.
  - 1 ORIGIN: [15:0] x0, [31:16] y0.
  - 2 SIZE: [15:0] w, [31:16] h.
  - 3 COLOR: [15:0] colour; upper bits read 0.
- Writes to registers 1–3 while BUSY are ignored. Reads are always valid.
- States: IDLE, CHECK, FILL, DONE_ST.
- IDLE:
  - START=1 with ABORT=0 → CHECK next cycle.
  - BUSY=1 from the cycle after the START write. Origin, size and colour are latched at that point.
- CHECK (1 cycle):
  - w==0 or h==0 → DONE_ST with no writes.
  - Otherwise, x0+w > DISPLAY_WIDTH or y0+h > DISPLAY_HEIGHT → set ERR, return to IDLE, no writes, DONE not set. Sums are computed at 17 bits, with no overflow wrap.
  - Otherwise load x=x0, y=y0, row_base=VRAM_START_ADDRESS + y0*DISPLAY_WIDTH → FILL. The multiply happens here only; row_base then advances by adding DISPLAY_WIDTH.
- FILL:
  - vram_wr_ena=1 and vram_wr_addr=row_base+x, both registered.
  - Output holds while vram_wr_ready=0; the request is never dropped or changed.
  - On ena&ready, advance:
    - x<x0+w-1 → x+1.
    - Else if y<y0+h-1 → x=x0, y+1, row_base+=DISPLAY_WIDTH.
    - Else last pixel → DONE_ST; vram_wr_ena low the next cycle.
  - Throughput: 1 pixel/cycle with ready held high. Exactly w*h writes, in row-major order.
- DONE_ST (1 cycle): set DONE, clear BUSY → IDLE.
- ABORT in CHECK or FILL:
  - → IDLE next cycle and vram_wr_ena=0 next cycle.
  - A handshake completing in the same cycle as the ABORT write counts; no further writes follow.
  - DONE is not set.
- START and ABORT in the same write: ABORT wins; no fill starts. START while BUSY is ignored.
- DONE_CLR in the same cycle DONE_ST sets DONE: the set wins. irq tracks DONE.
- Reset mid-FILL: vram_wr_ena drops asynchronously; no further writes occur.

Test Plan:
1. ORIGIN=0, SIZE={h=1,w=4}, COLOR=16'hF800, START, ready=1 → writes at base+0..3 with data F800 on 4 consecutive cycles; DONE=1, irq=1; DONE_CLR → irq=0.
2. ORIGIN={y=2,x=238}, SIZE={2,2}, ready=1 → addresses base+718, 719, 958, 959 in that order; no write at 720.
3. ORIGIN={0,239}, SIZE={1,2} → ERR=1, zero writes, DONE=0, BUSY=0 within 2 cycles. Also SIZE={5,0} → DONE=1, zero writes.
4. 2×2 fill with vram_wr_ready toggling 0,1,0,0,1,… → each addr/data held stable while ready=0; exactly 4 handshakes; order preserved.
5. 10×10 fill with ABORT written after 7 handshakes → at most 8 handshakes total, vram_wr_ena=0 next cycle, DONE=0, BUSY=0. A new START then runs normally.
6. Assert rst asynchronously mid-fill (between clock edges) → vram_wr_ena=0 immediately; all registers read 0 after release; START with prior values does nothing harmful (w=h=0 → DONE only).
